// File: rtl/reg_dump_reader.sv
// reg_dump_reader: walks a register file through one read port and streams each word with its address over valid/ready.
// Optional checksum trailer beat enabled by defining REG_DUMP_CHECKSUM_EN.
module reg_dump_reader #(
    parameter int FILE_WIDTH    = 32,
    parameter int REG_ADD_WIDTH = 5,
    parameter int NUM_REGS      = 32
) (
    input  logic                     CLK,
    input  logic                     rst,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [REG_ADD_WIDTH-1:0] rd_addr,
    input  logic [FILE_WIDTH-1:0]    rd_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [FILE_WIDTH-1:0]    out_data,
    output logic [REG_ADD_WIDTH-1:0] out_addr,
    output logic                     out_last
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_SEND  = 3'd2,
        S_CSUM  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [REG_ADD_WIDTH-1:0] LAST_ADDR = REG_ADD_WIDTH'(NUM_REGS - 1);
    localparam logic [REG_ADD_WIDTH-1:0] ADDR_ZERO = {REG_ADD_WIDTH{1'b0}};
    localparam logic [REG_ADD_WIDTH-1:0] ADDR_ONE  = REG_ADD_WIDTH'(1);
    localparam logic [FILE_WIDTH-1:0]    DATA_ZERO = {FILE_WIDTH{1'b0}};

    state_t                   state_q, state_d;
    logic [REG_ADD_WIDTH-1:0] addr_q, addr_d;
    logic                     valid_q, valid_d;
    logic [FILE_WIDTH-1:0]    data_q, data_d;
    logic [REG_ADD_WIDTH-1:0] oaddr_q, oaddr_d;
    logic                     last_q, last_d;
    logic                     hs_s;
    logic                     at_last_s;

`ifdef REG_DUMP_CHECKSUM_EN
    logic [FILE_WIDTH-1:0]    csum_q, csum_d;

    // Running XOR of every word captured during the current dump.
    always_ff @(posedge CLK) begin
        if (rst) begin
            csum_q <= DATA_ZERO;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

    assign hs_s      = valid_q && out_ready;
    assign at_last_s = (addr_q == LAST_ADDR);

    // Next-state and beat-register logic for the dump sequencer.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        valid_d = valid_q;
        data_d  = data_q;
        oaddr_d = oaddr_q;
        last_d  = last_q;
`ifdef REG_DUMP_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d  = ADDR_ZERO;
`ifdef REG_DUMP_CHECKSUM_EN
                    csum_d  = DATA_ZERO;
`endif
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                data_d  = rd_data;
                oaddr_d = addr_q;
                valid_d = 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
                last_d  = 1'b0;
                csum_d  = csum_q ^ rd_data;
`else
                last_d  = at_last_s;
`endif
                state_d = S_SEND;
            end
            S_SEND: begin
                if (hs_s) begin
                    if (!at_last_s) begin
                        addr_d  = addr_q + ADDR_ONE;
                        valid_d = 1'b0;
                        state_d = S_FETCH;
                    end else begin
`ifdef REG_DUMP_CHECKSUM_EN
                        // Trailer beat: accumulated XOR, reported at address 0.
                        data_d  = csum_q;
                        oaddr_d = ADDR_ZERO;
                        last_d  = 1'b1;
                        valid_d = 1'b1;
                        state_d = S_CSUM;
`else
                        valid_d = 1'b0;
                        state_d = S_DONE;
`endif
                    end
                end else begin
                    state_d = S_SEND;
                end
            end
`ifdef REG_DUMP_CHECKSUM_EN
            S_CSUM: begin
                if (hs_s) begin
                    valid_d = 1'b0;
                    state_d = S_DONE;
                end else begin
                    state_d = S_CSUM;
                end
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    // State and beat registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= ADDR_ZERO;
            valid_q <= 1'b0;
            data_q  <= DATA_ZERO;
            oaddr_q <= ADDR_ZERO;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            oaddr_q <= oaddr_d;
            last_q  <= last_d;
        end
    end

    assign busy      = (state_q == S_FETCH) || (state_q == S_SEND) || (state_q == S_CSUM);
    assign done      = (state_q == S_DONE);
    assign rd_addr   = addr_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_addr  = oaddr_q;
    assign out_last  = last_q;

endmodule
